// File: rtl/zap_fetch_queue.sv
// Instruction fetch front end: one request per cycle at the writeback PC, accepted responses
// buffered with PC+8/abort tags; flushes on any clear and parks after a prefetch abort.
module zap_fetch_queue #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  input  logic        i_thumb,
  input  logic        i_clear_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic        i_clear_from_decode,
  input  logic        i_stall,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_ack,
  input  logic [31:0] i_instr_data,
  input  logic        i_instr_abt,
  output logic        o_code_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus_8,
  output logic        o_instr_abt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        abt;
    logic [31:0] pc_plus_8;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;

  logic   flush;
  logic   full;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  assign flush = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign push  = !i_reset && (state == RUN) && i_instr_ack && !full && !flush;
  assign pop   = o_valid && !i_stall && !flush;

  always_comb begin
    push_entry           = '0;
    push_entry.instr     = i_instr_data;
    push_entry.abt       = i_instr_abt;
    push_entry.pc_plus_8 = i_pc + (i_thumb ? 32'd4 : 32'd8);
  end

  // The PC may only move when this very cycle's response was taken into the queue.
  assign o_code_stall = i_reset || (state == HALT) || !push;
  assign o_instr_req  = !i_reset && (state == RUN);
  assign o_instr_addr = i_pc & 32'hffff_fffe;

  assign o_valid = (count != '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    o_instr     = '0;
    o_pc_plus_8 = '0;
    o_instr_abt = 1'b0;
    if (o_valid) begin
      o_instr     = head.instr;
      o_pc_plus_8 = head.pc_plus_8;
      o_instr_abt = head.abt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        // An aborted fetch parks the front end until writeback redirects.
        if (i_instr_abt) begin
          state <= HALT;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/zap_fetch_queue.md
# zap_fetch_queue

Instruction-fetch front end that consumes the program counter driven by the writeback stage and returns fetched instructions to decode. It issues one instruction request per cycle at the writeback PC and generates the code-stall indication that freezes that PC. Accepted responses are buffered in a small FIFO with PC+8 and abort tags. It flushes on any pipeline clear and parks after an instruction abort until writeback redirects to the exception vector.

## Interface
- `FIFO_DEPTH`, 2: number of buffered instructions; power of two, ≥2.
- `i_clk` in 1: core clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_pc` in 32: current fetch PC, the writeback `o_pc`.
- `i_thumb` in 1: current CPSR T bit.
- `i_clear_from_writeback` in 1: flush.
- `i_clear_from_alu` in 1: flush.
- `i_clear_from_decode` in 1: flush.
- `i_stall` in 1: downstream (decode/issue/shifter/data) stall; holds the FIFO head.
- `o_instr_req` out 1: instruction memory request.
- `o_instr_addr` out 32: request address; `i_pc & 32'hffff_fffe`.
- `i_instr_ack` in 1: memory response valid this cycle.
- `i_instr_data` in 32: response data.
- `i_instr_abt` in 1: response carries a prefetch abort; qualified by `i_instr_ack`.
- `o_code_stall` out 1: to writeback `i_code_stall`; the PC must not advance.
- `o_valid` out 1: FIFO head valid.
- `o_instr` out 32: head instruction.
- `o_pc_plus_8` out 32: head fetch address + 8 (ARM) or + 4 (Thumb), sampled at fetch time.
- `o_instr_abt` out 1: head carries a prefetch abort.

## Operation
- State machine with two states.
  - RUN: `o_instr_req=1`.
  - HALT: `o_instr_req=0`.
- `flush` = OR of the three clear inputs.
- `push` = RUN & `i_instr_ack` & !full & !flush.
  - Entry pushed = {`i_instr_data`, `i_instr_abt`, `i_pc` + (`i_thumb` ? 4 : 8)}, 32-bit modulo add.
  - If `i_thumb`, the data is passed through unmodified; halfword selection belongs to decode.
- `pop` = `o_valid` & !`i_stall` & !flush.
- `o_code_stall` = !push | HALT. It is combinational from `i_instr_ack`, the full flag and the state.
  - The PC advances exactly when an instruction is accepted.
  - The combinational path does not include `i_stall`.
- Full means count == `FIFO_DEPTH`. A push is refused when full, even if a pop occurs in the same cycle; the request repeats at the same PC next cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Count is `$clog2(FIFO_DEPTH)+1` bits.
- Flush: next cycle count=0, pointers=0, state=RUN. Any ack in the flush cycle is discarded.
- A push with `i_instr_abt=1` moves RUN→HALT. In HALT, acks are ignored and `o_code_stall=1`.
- HALT→RUN only on flush. Writeback raises `i_clear_from_writeback` when the abort reaches it.
- Reset: count=0, pointers=0, state=RUN, FIFO storage zeroed. During reset `o_instr_req=0` and `o_code_stall=1`.
- Outputs `o_instr`, `o_pc_plus_8` and `o_instr_abt` are the head entry. They are 0 when the FIFO is empty (masked by !`o_valid`).

## Timing
- Ack at cycle N (accepted) → `o_valid=1` with that entry at N+1. Latency is 1 cycle.
- Flush at N → `o_valid=0` at N+1. The request at N+1 uses the redirected PC.
- Abort pushed at N → state HALT and `o_instr_req=0` from N+1 until a flush.
- Reset dominates flush, which dominates push/pop.
- Head holds stable while `i_stall=1`.
- No X on any output after the first reset edge.

## Test plan
- Reset, then `i_pc`=0x0 with ack every cycle and `i_stall=0`. Required: `o_code_stall=0`. The next cycle gives `o_valid=1` with `o_pc_plus_8`=0x8. Entries stream in order 0x8, 0xC, 0x10.
- `i_stall=1` for 4 cycles with acks continuing, `FIFO_DEPTH=2`. Required: after 2 pushes count=2 and `o_code_stall=1` while full. The head stays at its first entry. On release, pop order is preserved and there is no loss or duplicate.
- Thumb mode, `i_pc`=0x102, ack. Required: `o_instr_addr`=0x102 and `o_pc_plus_8`=0x106.
- Ack with `i_instr_abt=1` at PC 0x40. Required: head `o_instr_abt=1` with `o_pc_plus_8`=0x48. `o_instr_req=0` and `o_code_stall=1` until `i_clear_from_writeback`. Requests resume the cycle after the clear.
- FIFO holds 2 entries; `i_clear_from_alu` asserted in the same cycle as an ack. Required: the next cycle has `o_valid=0` and count 0. The acked data never appears at the output.
- Reset asserted mid-stream with a full FIFO and HALT state. Required: the next cycle has `o_valid=0` and state RUN, and `o_instr_req=0` while reset is held.
